// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared constants and types for the 4x32 architectural register file.
//   DATA_W     : register width in bits (multiple of 8)
//   NUM_REGS   : number of registers, fixed by the 2-bit index
//   REG_IDX_W  : register index width
//   NUM_LANES  : byte lanes per register
//   reg_idx_t  : register index type
//   merge_bytes: per-lane merge of new data over an old register value
package reg_file_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;
    localparam int NUM_LANES = DATA_W / 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Enabled lanes take new_val, the rest keep old_val.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]    old_val,
        input logic [DATA_W-1:0]    new_val,
        input logic [NUM_LANES-1:0] byte_en
    );
        logic [DATA_W-1:0] merged;
        merged = old_val;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (byte_en[k]) begin
                merged[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg32_be.sv
// reg32_be
// One register with synchronous active-high reset, a load enable and
// per-byte write enables. Lanes whose enable is clear hold their value.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, clears the register
//   load    : write strobe for this register
//   byte_en : per-lane enable, bit k covers d[8k+7:8k]
//   d       : write data
//   q       : register contents
module reg32_be
    import reg_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [NUM_LANES-1:0] byte_en,
    input  logic [DATA_W-1:0]    d,
    output logic [DATA_W-1:0]    q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (byte_en[k]) begin
                    q[8*k +: 8] <= d[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file4x32.sv
// reg_file4x32
// Four-entry register file with a byte-lane write port, two combinational
// read ports, flop outputs q1..q4 for the downstream read mux, and a busy
// scoreboard marking registers with an in-flight producer.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a read port that
// addresses the register being written returns the merged write value in
// the same cycle. q1..q4 are pure flop outputs in both builds.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   wr_en, wr_reg         : write request and destination
//   wr_byte_en, wr_data   : per-lane enables and write data
//   rsv_en, rsv_reg       : reserve request, sets busy[rsv_reg]
//   rd_reg_a, rd_reg_b    : read indices
//   rd_data_a, rd_data_b  : read data
//   q1..q4                : registers 0..3
//   busy                  : scoreboard, bit i = register i awaiting write
module reg_file4x32
    import reg_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [1:0]           wr_reg,
    input  logic [3:0]           wr_byte_en,
    input  logic [31:0]          wr_data,
    input  logic                 rsv_en,
    input  logic [1:0]           rsv_reg,
    input  logic [1:0]           rd_reg_a,
    input  logic [1:0]           rd_reg_b,
    output logic [31:0]          rd_data_a,
    output logic [31:0]          rd_data_b,
    output logic [31:0]          q1,
    output logic [31:0]          q2,
    output logic [31:0]          q3,
    output logic [31:0]          q4,
    output logic [3:0]           busy
);

    logic                eff_wr;
    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] rsv_dec;
    logic [NUM_REGS-1:0] busy_next;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // A write with no lanes enabled is not a write: no data change and it
    // must not retire the busy bit.
    assign eff_wr = wr_en && (|wr_byte_en);

    always_comb begin
        wr_dec = '0;
        if (eff_wr) begin
            wr_dec[wr_reg] = 1'b1;
        end
    end

    always_comb begin
        rsv_dec = '0;
        if (rsv_en) begin
            rsv_dec[rsv_reg] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        reg32_be u_reg (
            .clk     (clk),
            .reset   (reset),
            .load    (wr_dec[i]),
            .byte_en (wr_byte_en),
            .d       (wr_data),
            .q       (regs[i])
        );
    end

    // Reserve is applied after the clear so a new producer issuing in the
    // same cycle as the old one retiring leaves the register busy.
    assign busy_next = (busy & ~wr_dec) | rsv_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_reg_a];
        rd_data_b = regs[rd_reg_b];
`ifdef REGFILE_BYPASS_EN
        if (eff_wr && (wr_reg == rd_reg_a)) begin
            rd_data_a = merge_bytes(regs[rd_reg_a], wr_data, wr_byte_en);
        end
        if (eff_wr && (wr_reg == rd_reg_b)) begin
            rd_data_b = merge_bytes(regs[rd_reg_b], wr_data, wr_byte_en);
        end
`endif
    end

    assign q1 = regs[0];
    assign q2 = regs[1];
    assign q3 = regs[2];
    assign q4 = regs[3];

endmodule

// File: tb/tb_reg_file4x32.sv
module tb_reg_file4x32;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_reg;
    logic [3:0]  wr_byte_en;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [1:0]  rsv_reg;
    logic [1:0]  rd_reg_a;
    logic [1:0]  rd_reg_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] q1, q2, q3, q4;
    logic [3:0]  busy;
    logic [31:0] q_all [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign q_all[0] = q1;
    assign q_all[1] = q2;
    assign q_all[2] = q3;
    assign q_all[3] = q4;

    reg_file4x32 dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_byte_en (wr_byte_en),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_reg    (rsv_reg),
        .rd_reg_a   (rd_reg_a),
        .rd_reg_b   (rd_reg_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .q4         (q4),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_reg     = 2'd0;
        wr_byte_en = 4'h0;
        wr_data    = 32'h0;
        rsv_en     = 1'b0;
        rsv_reg    = 2'd0;
    endtask

    task automatic do_write(input logic [1:0] r, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_reg = r; wr_byte_en = be; wr_data = d;
        tick();
        idle();
    endtask

    task automatic do_reserve(input logic [1:0] r);
        rsv_en = 1'b1; rsv_reg = r;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_write(2'd0, 4'hF, 32'hA5A5A5A5);
        do_write(2'd2, 4'hF, 32'h5A5A5A5A);
        do_reserve(2'd1);
        #1;
        checks++;
        if (q1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL pre_reset_q1: got %h want %h", q1, 32'hA5A5A5A5); end
        checks++;
        if (q3 !== 32'h5A5A5A5A) begin errors++; $display("FAIL pre_reset_q3: got %h want %h", q3, 32'h5A5A5A5A); end
        checks++;
        if (busy !== 4'b0010) begin errors++; $display("FAIL pre_reset_busy: got %b want %b", busy, 4'b0010); end
        // Reset together with a write and a reserve: reset must win.
        reset = 1'b1;
        wr_en = 1'b1; wr_reg = 2'd2; wr_byte_en = 4'hF; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_reg = 2'd2;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_all[i] !== 32'h0) begin errors++; $display("FAIL reset_q%0d: got %h want %h", i + 1, q_all[i], 32'h0); end
        end
        checks++;
        if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b want %b", busy, 4'b0000); end
        tick();
        checks++;
        if (q3 !== 32'h0) begin errors++; $display("FAIL reset_write_discarded: got %h want %h", q3, 32'h0); end
    endtask

    task automatic test_byte_write();
        do_write(2'd1, 4'hF, 32'h12345678);
        checks++;
        if (q2 !== 32'h12345678) begin errors++; $display("FAIL full_write_q2: got %h want %h", q2, 32'h12345678); end
        do_write(2'd1, 4'b0101, 32'hAABBCCDD);
        checks++;
        if (q2 !== 32'h12BB56DD) begin errors++; $display("FAIL lane_write_q2: got %h want %h", q2, 32'h12BB56DD); end
        checks++;
        if (q1 !== 32'h0 || q3 !== 32'h0 || q4 !== 32'h0) begin
            errors++; $display("FAIL lane_write_others: got %h %h %h want 0", q1, q3, q4);
        end
    endtask

    task automatic test_scoreboard();
        do_reserve(2'd3);
        checks++;
        if (busy !== 4'b1000) begin errors++; $display("FAIL rsv3_busy: got %b want %b", busy, 4'b1000); end
        wr_en = 1'b1; wr_reg = 2'd3; wr_byte_en = 4'hF; wr_data = 32'h00000033;
        rsv_en = 1'b1; rsv_reg = 2'd3;
        tick();
        idle();
        checks++;
        if (busy !== 4'b1000) begin errors++; $display("FAIL wr_rsv_same_busy: got %b want %b", busy, 4'b1000); end
        checks++;
        if (q4 !== 32'h00000033) begin errors++; $display("FAIL wr_rsv_same_q4: got %h want %h", q4, 32'h00000033); end
        do_write(2'd3, 4'hF, 32'h00000044);
        checks++;
        if (busy !== 4'b0000) begin errors++; $display("FAIL wr_clears_busy: got %b want %b", busy, 4'b0000); end
        checks++;
        if (q4 !== 32'h00000044) begin errors++; $display("FAIL wr_q4: got %h want %h", q4, 32'h00000044); end
        do_reserve(2'd1);
        do_reserve(2'd2);
        do_reserve(2'd2);
        checks++;
        if (busy !== 4'b0110) begin errors++; $display("FAIL rsv12_busy: got %b want %b", busy, 4'b0110); end
        do_write(2'd1, 4'b0001, 32'h00000001);
        checks++;
        if (busy !== 4'b0100) begin errors++; $display("FAIL clear_only_target: got %b want %b", busy, 4'b0100); end
        checks++;
        if (q2 !== 32'h12BB5601) begin errors++; $display("FAIL lane0_q2: got %h want %h", q2, 32'h12BB5601); end
        do_reserve(2'd0);
        checks++;
        if (busy !== 4'b0101) begin errors++; $display("FAIL rsv0_busy: got %b want %b", busy, 4'b0101); end
    endtask

    task automatic test_zero_be();
        do_write(2'd0, 4'h0, 32'hFFFFFFFF);
        checks++;
        if (q1 !== 32'h0) begin errors++; $display("FAIL zero_be_q1: got %h want %h", q1, 32'h0); end
        checks++;
        if (busy !== 4'b0101) begin errors++; $display("FAIL zero_be_busy: got %b want %b", busy, 4'b0101); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a;
        wr_en = 1'b1; wr_reg = 2'd2; wr_byte_en = 4'hF; wr_data = 32'hCAFEF00D;
        rd_reg_a = 2'd2; rd_reg_b = 2'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'hCAFEF00D;
`else
        exp_a = 32'h0;
`endif
        checks++;
        if (rd_data_a !== exp_a) begin errors++; $display("FAIL bypass_a: got %h want %h", rd_data_a, exp_a); end
        checks++;
        if (rd_data_b !== exp_a) begin errors++; $display("FAIL bypass_b: got %h want %h", rd_data_b, exp_a); end
        checks++;
        if (q3 !== 32'h0) begin errors++; $display("FAIL bypass_q3_flop: got %h want %h", q3, 32'h0); end
        tick();
        idle();
        checks++;
        if (rd_data_a !== 32'hCAFEF00D || rd_data_b !== 32'hCAFEF00D) begin
            errors++; $display("FAIL post_write_rd: got %h %h want %h", rd_data_a, rd_data_b, 32'hCAFEF00D);
        end
        checks++;
        if (busy !== 4'b0001) begin errors++; $display("FAIL post_write_busy: got %b want %b", busy, 4'b0001); end
        // Partial-lane write: bypass must merge with the old bytes.
        wr_en = 1'b1; wr_reg = 2'd2; wr_byte_en = 4'b0011; wr_data = 32'h12345678;
        rd_reg_a = 2'd2; rd_reg_b = 2'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'hCAFE5678;
`else
        exp_a = 32'hCAFEF00D;
`endif
        checks++;
        if (rd_data_a !== exp_a) begin errors++; $display("FAIL bypass_merge_a: got %h want %h", rd_data_a, exp_a); end
        checks++;
        if (rd_data_b !== 32'h0) begin errors++; $display("FAIL bypass_other_b: got %h want %h", rd_data_b, 32'h0); end
        tick();
        idle();
        // A zero-lane write must never bypass.
        wr_en = 1'b1; wr_reg = 2'd2; wr_byte_en = 4'h0; wr_data = 32'h0;
        #1;
        checks++;
        if (rd_data_a !== 32'hCAFE5678) begin errors++; $display("FAIL zero_be_no_bypass: got %h want %h", rd_data_a, 32'hCAFE5678); end
        tick();
        idle();
        checks++;
        if (q3 !== 32'hCAFE5678) begin errors++; $display("FAIL merge_q3: got %h want %h", q3, 32'hCAFE5678); end
    endtask

    task automatic test_walk();
        logic [31:0] exp [4];
        exp[0] = 32'h11111111; exp[1] = 32'h22222222;
        exp[2] = 32'h33333333; exp[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) do_write(2'(i), 4'hF, exp[i]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_all[i] !== exp[i]) begin errors++; $display("FAIL walk_q%0d: got %h want %h", i + 1, q_all[i], exp[i]); end
        end
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                rd_reg_a = 2'(a); rd_reg_b = 2'(b);
                #1;
                checks++;
                if (rd_data_a !== exp[a] || rd_data_b !== exp[b]) begin
                    errors++;
                    $display("FAIL walk_rd a=%0d b=%0d: got %h %h want %h %h", a, b, rd_data_a, rd_data_b, exp[a], exp[b]);
                end
            end
        end
    endtask

    initial begin
        idle();
        rd_reg_a = 2'd0;
        rd_reg_b = 2'd0;
        reset = 1'b1;
        tick();
        tick();
        idle();
        test_reset();
        test_byte_write();
        test_scoreboard();
        test_zero_be();
        test_bypass();
        test_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file4x32.md
# reg_file4x32

Four-entry, 32-bit architectural register file that sits directly upstream of the 4:1 register read multiplexer and drives its `q1`..`q4` inputs. It also provides two internal read ports, a byte-lane write port and a per-register busy scoreboard for in-flight results. All state updates on the rising edge of one clock.

## Interface
- `DATA_W`, 32: register width; must be a multiple of 8 (byte lanes = `DATA_W/8`)
- `NUM_REGS`, 4: register count; fixed at 4 by the 2-bit index
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high; one clock has the only clock domain
- `wr_en` in 1: write request
- `wr_reg` in 2: write destination index
- `wr_byte_en` in 4: per-byte write enable; bit k covers `wr_data[8k+7:8k]`
- `wr_data` in 32: write data
- `rsv_en` in 1: reserve request; marks `rsv_reg` busy
- `rsv_reg` in 2: register to reserve
- `rd_reg_a`, `rd_reg_b` in 2: read indices
- `rd_data_a`, `rd_data_b` out 32: read data
- `q1`, `q2`, `q3`, `q4` out 32: registers 0..3, driven straight from flops to the downstream read mux
- `busy` out 4: scoreboard; bit i = register i awaiting write

## Operation
- Reset: all four registers, and therefore `q1`..`q4`, become 0x0000_0000. `busy` becomes 4'b0000. Reset wins over any write or reserve in the same cycle.
- Write: the 2-to-4 decode of `wr_reg`, gated by `wr_en`, selects one register. Each byte lane with its `wr_byte_en` bit set loads `wr_data`. Lanes not enabled keep their old value.
- Effective write: `wr_en && |wr_byte_en`. When `wr_en` is high but `wr_byte_en` is 0, there is no state change and `busy` is not cleared.
- Scoreboard:
  - An effective write clears `busy[wr_reg]`.
  - `rsv_en` sets `busy[rsv_reg]`.
  - If both target the same register in the same cycle, the reserve wins and busy ends at 1 (a new producer has issued).
  - Reserving an already-busy register is legal and has no extra effect.
- Reads: `rd_data_a`/`rd_data_b` are combinational selects of the current register contents by `rd_reg_a`/`rd_reg_b`. Both ports may address the same register.
- `busy` is advisory only. Writes and reads are never blocked by it.

## Timing
- Write latency: data is visible on `q*` and the read ports in the cycle after the write edge.
- Busy set/clear is visible one cycle after the request edge.
- Read ports: zero-cycle combinational path from `rd_reg_*` to `rd_data_*`.
- Reset: takes effect on the first rising edge with `reset`=1. A write issued in the same cycle as reset is discarded. Writes after reset deassertion proceed normally.
- No handshake back-pressure: every request is accepted on the cycle it is presented.

## Configuration
- `REGFILE_BYPASS_EN`
  - Defined: when an effective write targets the register addressed by `rd_reg_a`/`rd_reg_b`, that read port returns the merged value (new bytes for enabled lanes, old bytes otherwise) in the same cycle.
  - Undefined: read ports return pre-write contents until the next cycle.
- `q1`..`q4` are always pure flop outputs in both builds.

## Structure
- Package `reg_file_pkg`:
  - `DATA_W`, `NUM_REGS`, `REG_IDX_W`=2 and `NUM_LANES`=4 constants
  - a `reg_idx_t` typedef for 2-bit indices
- One sub-module, `reg32_be`:
  - a single 32-bit register with synchronous active-high reset, a load enable and per-byte enables
  - instantiated four times, selected by the write decode

## Test plan
- Reset with `wr_en`=1, `wr_reg`=2, `wr_data`=0xDEADBEEF in the same cycle -> next cycle all `q*` = 0, `busy`=0.
- Write reg1 = 0x12345678 with `wr_byte_en`=4'hF, then reg1 with `wr_byte_en`=4'b0101 and data 0xAABBCCDD -> `q2` = 0x12BB56DD.
- `rsv_en` on reg3 -> `busy`=4'b1000. Then an effective write plus `rsv_en` on reg3 in the same cycle -> `busy[3]` stays 1. A later write alone -> `busy[3]`=0.
- `wr_en`=1 with `wr_byte_en`=0 to busy reg0 -> `q1` unchanged, `busy[0]` stays 1.
- Write reg2 = 0xCAFEF00D while `rd_reg_a`=`rd_reg_b`=2 -> same cycle `rd_data_a` = 0xCAFEF00D with `REGFILE_BYPASS_EN`, old value without. Next cycle both read 0xCAFEF00D.
- Walk writes 0x11111111..0x44444444 into regs 0..3 -> `q1`..`q4` match, and every `rd_reg_a`/`rd_reg_b` combination returns the correct value.
